event_bfm_arb: RTL and testbench
================================

Name: event_bfm_arb

Overview:
- Arbitrates several event-vector sources onto one event-reporting channel. Typical sources are the DMA channel done/irq/error bundles.
- Detects value changes on each source and holds the latest snapshot per source. Coalesces repeat changes while a report is pending.
- Issues one report at a time, round-robin, over a valid/ready handshake.
- The downstream consumer is the single event-reporting BFM core, which then needs only one registration for all sources.

Parameters:
- N_SRC, 4, number of event sources (2..16).
- WIDTH, 32, bits per source event vector (1..64).
- ID_W, $clog2(N_SRC), derived localparam; width of the source id. Not overridable.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- ev  input  N_SRC*WIDTH  source event vectors. Source i occupies bits [i*WIDTH +: WIDTH].
- out_valid  output  1  report available.
- out_ready  input  1  consumer accepts the report when out_valid && out_ready at a clock edge.
- out_id  output  ID_W  source index of the report.
- out_ev  output  WIDTH  snapshot value of the reported source.
- out_coalesced  output  1  at least one intermediate value of this source was overwritten before reporting.
- pending  output  N_SRC  per-source report-pending status.

Behaviour:
- Reset (rst=1 at an edge):
  - out_valid=0; out_id=0, out_ev=0, out_coalesced=0.
  - pending=0, all snapshots=0, all last-values (ev_r)=0.
  - Per-source init flag set to 1.
  - Round-robin pointer = N_SRC-1, so source 0 is served first.
  - An in-flight report is dropped and is not retried.
- Capture, per source i, at each non-reset edge:
  - Capture when init[i] || ev[i] != ev_r[i].
  - On capture: snap[i]<=ev[i], ev_r[i]<=ev[i], pend[i]<=1, init[i]<=0.
  - Consequence: every source reports its value once after reset, even if that value is zero.
- Coalescing:
  - If pend[i] is already 1, i is not granted this edge, and a capture occurs: coal[i]<=1 and the snapshot is overwritten (latest value wins).
- Grant: the output register loads when out_valid==0 || out_ready==1, and any pend bit is set.
  - Winner = first set pend bit searching from pointer+1, wrapping modulo N_SRC.
  - out_valid<=1, out_id<=winner, out_ev<=snap[winner], out_coalesced<=coal[winner].
  - pend[winner]<=0, coal[winner]<=0, pointer<=winner.
  - If no pend bit is set and out_ready==1: out_valid<=0.
- Simultaneous grant and capture on the winner:
  - Output receives the old snapshot.
  - New snapshot is stored; pend stays 1 and coal<=0. The new value is a fresh report, not a coalesce.
- Hold: while out_valid && !out_ready, out_id, out_ev and out_coalesced stay stable and no grant occurs.
- Latency: an ev change present at edge k gives out_valid=1 after edge k+1, provided the output is free and no other source is pending.
- Throughput: one report per cycle while out_ready is held high.
- Fairness: with all sources continuously pending, grants rotate 0,1,..,N_SRC-1,0. Maximum wait for any source is N_SRC reports.
- pending output: direct copy of the pend register.
- No combinational path from ev or out_ready to any output.

Decomposition:
- Package event_bfm_arb_pkg:
  - Parameterised report struct fields (id, ev, coalesced).
  - Function rr_pick(pend, ptr) returning the winner index and found flag.
- Sub-module event_bfm_arb_rr: round-robin picker.
  - Combinational winner search.
  - Pointer register updated on grant; pointer reset to N_SRC-1.
  - Roughly 60 lines.
- Top level holds the per-source capture/coalesce registers and the output register.

Test Plan:
- Post-reset init: N_SRC=4, all ev=0, rst released, out_ready=1 → four reports, ids 0,1,2,3 on consecutive cycles, out_ev=0, out_coalesced=0. Then out_valid=0.
- Single change: ev[1]=0x5 at edge k, out_ready=1 → out_valid=1 after k+1 with out_id=1, out_ev=0x5. pending=0 after the handshake.
- Coalesce: out_ready=0 holding a source-0 report. ev[2] changes 0x1, then 0x2, then 0x3 on consecutive cycles. Then out_ready=1 → source 2 is reported once, out_ev=0x3, out_coalesced=1.
- Round-robin fairness: all four sources toggle every cycle, out_ready=1 for 12 cycles → id sequence 0,1,2,3 repeated three times, no source skipped.
- Grant/capture collision: source 3 is granted at edge k while ev[3] changes 0xA→0xB at k → report carries 0xA. A second report carries 0xB with out_coalesced=0.
- Backpressure and reset: out_ready=0 with out_valid=1 for 5 cycles → outputs stable. Assert rst mid-hold → out_valid=0 next cycle, pending=0, the init reports repeat after release.

Source files
------------

// File: rtl/event_bfm_arb_pkg.sv
// Shared types and helpers for the event-source arbiter: report record
// layout and the round-robin winner search.
package event_bfm_arb_pkg;

    localparam int MAX_SRC   = 16;
    localparam int MAX_WIDTH = 64;
    localparam int MAX_ID_W  = 4;

    // Report record sized for the largest legal configuration; the top
    // narrows each field to its actual parameters.
    typedef struct packed {
        logic [MAX_ID_W-1:0]  id;
        logic [MAX_WIDTH-1:0] ev;
        logic                 coalesced;
    } report_t;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } pick_t;

    // First set pend bit searching from ptr+1, wrapping modulo n_src.
    // Scanning from the far end lets the nearest candidate overwrite the rest.
    function automatic pick_t rr_pick(input logic [MAX_SRC-1:0]  pend,
                                      input logic [MAX_ID_W-1:0] ptr,
                                      input int                  n_src);
        pick_t               res;
        logic [MAX_ID_W-1:0] cand;
        res.found = 1'b0;
        res.idx   = {MAX_ID_W{1'b0}};
        for (int k = MAX_SRC; k >= 1; k--) begin
            if (k <= n_src) begin
                cand = MAX_ID_W'((int'(ptr) + k) % n_src);
                if (pend[cand]) begin
                    res.found = 1'b1;
                    res.idx   = cand;
                end else begin
                    res.found = res.found;
                end
            end else begin
                res.found = res.found;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/event_bfm_arb_rr.sv
// Round-robin picker: combinational winner search over the pending mask
// plus the pointer register that remembers the last granted source.
module event_bfm_arb_rr
    import event_bfm_arb_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] pend,
    input  logic             grant,
    output logic [ID_W-1:0]  winner,
    output logic             found
);

    logic [ID_W-1:0] ptr_r;
    pick_t           pick_s;

    // Winner search starts just after the last granted source.
    always_comb begin
        pick_s = rr_pick(MAX_SRC'(pend), MAX_ID_W'(ptr_r), N_SRC);
        winner = ID_W'(pick_s.idx);
        found  = pick_s.found;
    end

    // Pointer parks on the last source so source 0 is served first after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= ID_W'(N_SRC - 1);
        end else if (grant) begin
            ptr_r <= winner;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/event_bfm_arb.sv
// Event-source arbiter: captures value changes per source, coalesces
// repeats while a report is pending, and presents one report at a time
// round-robin over a valid/ready channel.
module event_bfm_arb
    import event_bfm_arb_pkg::*;
#(
    parameter  int N_SRC = 4,
    parameter  int WIDTH = 32,
    localparam int ID_W  = $clog2(N_SRC)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_SRC*WIDTH-1:0] ev,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ID_W-1:0]        out_id,
    output logic [WIDTH-1:0]       out_ev,
    output logic                   out_coalesced,
    output logic [N_SRC-1:0]       pending
);

    logic [WIDTH-1:0] ev_s   [N_SRC];
    logic [WIDTH-1:0] snap_r [N_SRC];
    logic [WIDTH-1:0] last_r [N_SRC];
    logic [N_SRC-1:0] pend_r;
    logic [N_SRC-1:0] coal_r;
    logic [N_SRC-1:0] init_r;
    logic [N_SRC-1:0] capture_s;
    logic [N_SRC-1:0] grant_vec_s;
    logic             load_s;
    logic             found_s;
    logic [ID_W-1:0]  winner_s;
    logic             out_valid_r;
    report_t          out_r;
    report_t          next_s;

    for (genvar g = 0; g < N_SRC; g++) begin : g_src
        assign ev_s[g]      = ev[g*WIDTH +: WIDTH];
        assign capture_s[g] = init_r[g] || (ev_s[g] != last_r[g]);
    end

    event_bfm_arb_rr #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_rr (
        .clk    (clk),
        .rst    (rst),
        .pend   (pend_r),
        .grant  (load_s),
        .winner (winner_s),
        .found  (found_s)
    );

    // Output slot is free when empty or being drained this edge.
    always_comb begin
        load_s = (!out_valid_r || out_ready) && found_s;
        if (load_s) begin
            grant_vec_s = {{(N_SRC-1){1'b0}}, 1'b1} << winner_s;
        end else begin
            grant_vec_s = {N_SRC{1'b0}};
        end
        next_s.id        = MAX_ID_W'(winner_s);
        next_s.ev        = MAX_WIDTH'(snap_r[winner_s]);
        next_s.coalesced = coal_r[winner_s];
    end

    // Per-source capture; a capture on the winner is a fresh report, so it
    // re-arms pend without marking a coalesce.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_SRC; i++) begin
                snap_r[i] <= {WIDTH{1'b0}};
                last_r[i] <= {WIDTH{1'b0}};
            end
            pend_r <= {N_SRC{1'b0}};
            coal_r <= {N_SRC{1'b0}};
            init_r <= {N_SRC{1'b1}};
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (capture_s[i]) begin
                    snap_r[i] <= ev_s[i];
                    last_r[i] <= ev_s[i];
                    init_r[i] <= 1'b0;
                    pend_r[i] <= 1'b1;
                end else if (grant_vec_s[i]) begin
                    pend_r[i] <= 1'b0;
                end else begin
                    pend_r[i] <= pend_r[i];
                end
                if (grant_vec_s[i]) begin
                    coal_r[i] <= 1'b0;
                end else if (capture_s[i] && pend_r[i]) begin
                    coal_r[i] <= 1'b1;
                end else begin
                    coal_r[i] <= coal_r[i];
                end
            end
        end
    end

    // Output register: load on grant, drop valid once drained, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_r       <= '0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_r       <= next_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid     = out_valid_r;
    assign out_id        = ID_W'(out_r.id);
    assign out_ev        = WIDTH'(out_r.ev);
    assign out_coalesced = out_r.coalesced;
    assign pending       = pend_r;

endmodule

// File: tb/tb_event_bfm_arb.sv
// Directed bench for event_bfm_arb: expected reports are queued as stimulus
// is applied and popped as the arbiter presents them.
module tb_event_bfm_arb;

    localparam int N_SRC = 4;
    localparam int WIDTH = 32;
    localparam int ID_W  = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_SRC*WIDTH-1:0] ev;
    logic                   out_valid;
    logic                   out_ready;
    logic [ID_W-1:0]        out_id;
    logic [WIDTH-1:0]       out_ev;
    logic                   out_coalesced;
    logic [N_SRC-1:0]       pending;

    typedef struct {
        int          id;
        logic [31:0] ev;
        logic        coal;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    event_bfm_arb #(.N_SRC(N_SRC), .WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .ev            (ev),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_id        (out_id),
        .out_ev        (out_ev),
        .out_coalesced (out_coalesced),
        .pending       (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [31:0] v);
        ev[i*WIDTH +: WIDTH] = v;
    endtask

    task automatic push(input int id, input logic [31:0] v, input logic c);
        exp_t e;
        e.id   = id;
        e.ev   = v;
        e.coal = c;
        exp_q.push_back(e);
    endtask

    task automatic expect_report(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=report_request expected=queued_report", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_valid"}, 64'(out_valid), 64'd1);
            chk({tag, "_id"}, 64'(out_id), 64'(e.id));
            chk({tag, "_ev"}, 64'(out_ev), 64'(e.ev));
            chk({tag, "_coal"}, 64'(out_coalesced), 64'(e.coal));
        end
    endtask

    function automatic logic [31:0] fv(input int c, input int i);
        return 32'(32'h100 * c + i + 1);
    endfunction

    initial begin
        rst       = 1'b1;
        ev        = '0;
        out_ready = 1'b1;
        repeat (3) step();
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_id", 64'(out_id), 64'd0);
        chk("reset_ev", 64'(out_ev), 64'd0);
        chk("reset_coal", 64'(out_coalesced), 64'd0);
        chk("reset_pending", 64'(pending), 64'd0);

        // Post-reset init reports
        rst = 1'b0;
        step();
        chk("init_capture_valid", 64'(out_valid), 64'd0);
        chk("init_capture_pending", 64'(pending), 64'hf);
        for (int i = 0; i < N_SRC; i++) push(i, 32'h0, 1'b0);
        for (int i = 0; i < N_SRC; i++) begin
            step();
            expect_report("init");
        end
        step();
        chk("init_done_valid", 64'(out_valid), 64'd0);
        chk("init_done_pending", 64'(pending), 64'd0);

        // Single change with one-cycle latency
        set_src(1, 32'h5);
        push(1, 32'h5, 1'b0);
        step();
        chk("single_latency_valid", 64'(out_valid), 64'd0);
        chk("single_pending", 64'(pending), 64'h2);
        step();
        expect_report("single");
        step();
        chk("single_after_valid", 64'(out_valid), 64'd0);
        chk("single_after_pending", 64'(pending), 64'd0);

        // Coalesce while a source-0 report is held
        set_src(0, 32'h7);
        out_ready = 1'b0;
        push(0, 32'h7, 1'b0);
        step();
        step();
        expect_report("coal_held_src0");
        set_src(2, 32'h1);
        step();
        set_src(2, 32'h2);
        step();
        set_src(2, 32'h3);
        step();
        chk("coal_pending", 64'(pending), 64'h4);
        chk("coal_hold_valid", 64'(out_valid), 64'd1);
        chk("coal_hold_id", 64'(out_id), 64'd0);
        chk("coal_hold_ev", 64'(out_ev), 64'h7);
        push(2, 32'h3, 1'b1);
        out_ready = 1'b1;
        step();
        expect_report("coal_src2");
        step();
        chk("coal_after_valid", 64'(out_valid), 64'd0);

        // Grant and capture on the same source at the same edge
        set_src(3, 32'hA);
        push(3, 32'hA, 1'b0);
        step();
        chk("collide_pending", 64'(pending), 64'h8);
        set_src(3, 32'hB);
        push(3, 32'hB, 1'b0);
        step();
        expect_report("collide_old");
        chk("collide_pend_kept", 64'(pending), 64'h8);
        step();
        expect_report("collide_new");
        step();
        chk("collide_after_valid", 64'(out_valid), 64'd0);

        // Fairness: every source changes every cycle
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < N_SRC; i++) set_src(i, fv(c, i));
            push(c % N_SRC, fv(c, c % N_SRC), (c != 0));
            step();
            if (c == 0) begin
                chk("fair_first_valid", 64'(out_valid), 64'd0);
            end else begin
                expect_report("fair");
            end
        end
        push(0, fv(11, 0), 1'b1);
        push(1, fv(11, 1), 1'b1);
        push(2, fv(11, 2), 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            expect_report("fair_tail");
        end
        step();
        chk("fair_done_valid", 64'(out_valid), 64'd0);
        chk("fair_done_pending", 64'(pending), 64'd0);

        // Backpressure hold, then reset mid-hold
        out_ready = 1'b0;
        set_src(1, 32'hDEAD_0001);
        push(1, 32'hDEAD_0001, 1'b0);
        step();
        step();
        expect_report("bp_first");
        for (int k = 0; k < 5; k++) begin
            step();
            chk("bp_hold_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_id", 64'(out_id), 64'd1);
            chk("bp_hold_ev", 64'(out_ev), 64'hDEAD_0001);
            chk("bp_hold_coal", 64'(out_coalesced), 64'd0);
        end
        rst = 1'b1;
        step();
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_pending", 64'(pending), 64'd0);
        chk("rst_mid_ev", 64'(out_ev), 64'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        step();
        chk("reinit_pending", 64'(pending), 64'hf);
        push(0, fv(11, 0), 1'b0);
        push(1, 32'hDEAD_0001, 1'b0);
        push(2, fv(11, 2), 1'b0);
        push(3, fv(11, 3), 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            expect_report("reinit");
        end
        step();
        chk("reinit_done_valid", 64'(out_valid), 64'd0);
        chk("reinit_done_pending", 64'(pending), 64'd0);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
